slice_packer: RTL and testbench



---
 rtl/slice_packer.sv | 134 +++++++++++++
 tb/tb_slice_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/slice_packer.sv
// Registered slice/concatenate/mask packer: each accepted beat yields one chunk,
// and chunks are packed MSB-first into a BEATS-chunk word, replicated, or flushed early.
module slice_packer #(
    parameter int unsigned         IN_W    = 8,
    parameter int unsigned         SLICE_W = 4,
    parameter int unsigned         BEATS   = 3,
    parameter logic [2*SLICE_W-1:0] MASK   = '1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_W-1:0]                 a,
    input  logic [IN_W-1:0]                 b,
    input  logic                            mode,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BEATS*2*SLICE_W-1:0]      out_data,
    output logic [$clog2(BEATS+1)-1:0]      out_chunks
);

    localparam int unsigned CH_W  = 2 * SLICE_W;
    localparam int unsigned OUT_W = BEATS * CH_W;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic {
        MODE_PACK = 1'b0,
        MODE_REPL = 1'b1
    } mode_e;

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            lmode_q, lmode_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_chunks_q, out_chunks_d;

    logic [CH_W-1:0]  chunk;
    mode_e            eff_mode;
    logic             can_load;
    logic             completes;
    logic             in_ready_c;
    logic             accept;
    logic             do_complete;
    logic             do_flush;
    logic             do_load;
    logic [CNT_W-1:0] present;
    logic [OUT_W-1:0] acc_ins;
    logic [OUT_W-1:0] acc_new;

    assign chunk = {a[IN_W-1 -: SLICE_W], b[SLICE_W-1:0]} & MASK;

    generate
        if (SLICE_W < IN_W) begin : g_unused
            logic unused_bits;
            assign unused_bits = ^{a[IN_W-SLICE_W-1:0], b[IN_W-1:SLICE_W]};
        end
    endgenerate

    always_comb begin
        can_load  = !out_valid_q || out_ready;
        eff_mode  = (cnt_q == '0) ? mode_e'(mode) : lmode_q;
        completes = ((eff_mode == MODE_REPL) && (cnt_q == '0)) || (cnt_q == LAST);
        // Only a beat that would need the output register stalls behind a held word.
        in_ready_c = can_load || !(completes || flush);
        accept     = in_valid && in_ready_c;

        acc_ins = acc_q;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                acc_ins[OUT_W-1-k*CH_W -: CH_W] = chunk;
            end
        end
        acc_new = accept ? acc_ins : acc_q;

        present     = cnt_q + CNT_W'(accept);
        do_complete = accept && completes;
        do_flush    = flush && can_load && (present != '0);
        do_load     = do_complete || do_flush;

        acc_d        = acc_new;
        cnt_d        = accept ? cnt_q + CNT_W'(1) : cnt_q;
        lmode_d      = (accept && (cnt_q == '0)) ? mode_e'(mode) : lmode_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chunks_d = out_chunks_q;

        if (do_load) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            if (do_complete && (eff_mode == MODE_REPL)) begin
                out_data_d   = {BEATS{chunk}};
                out_chunks_d = CNT_W'(BEATS);
            end else begin
                out_data_d   = acc_new;
                out_chunks_d = present;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            lmode_q      <= MODE_PACK;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chunks_q <= '0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            lmode_q      <= lmode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chunks_q <= out_chunks_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chunks = out_chunks_q;

    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt_q < CNT_W'(BEATS));
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_chunks_q)));

endmodule

// File: tb/tb_slice_packer.sv
// Randomized bench for slice_packer against a queue-based word model, plus
// directed scenarios on mask and parameter variants.
module tb_slice_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        mode = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [23:0] out_data;
    logic [1:0]  out_chunks;

    logic        m_in_ready, m_out_valid;
    logic [23:0] m_out_data;
    logic [1:0]  m_out_chunks;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [2:0]  s_out_chunks;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model: chunks of the word in progress, and the expected output register.
    int unsigned mq[$];
    bit          m_wmode;
    bit          mdl_ov;
    logic [23:0] mdl_od;
    int unsigned mdl_oc;
    bit          last_rdy;

    always #5 clk = ~clk;

    slice_packer u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chunks(out_chunks)
    );

    slice_packer #(.MASK(8'h30)) u_mask (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .a(a), .b(b), .mode(mode), .flush(flush),
        .out_valid(m_out_valid), .out_ready(out_ready),
        .out_data(m_out_data), .out_chunks(m_out_chunks)
    );

    slice_packer #(.SLICE_W(2), .BEATS(4)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .mode(mode), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_chunks(s_out_chunks)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] ia, input logic [7:0] ib,
                        input bit im, input bit fl, input bit ordy);
        bit          can_load, emode, wc, exp_rdy, acc;
        int unsigned ch, n;
        logic [23:0] w;
        @(negedge clk);
        in_valid = v; a = ia; b = ib; mode = im; flush = fl; out_ready = ordy;
        #1;
        ch       = int'(ia & 8'hF0) | int'(ib & 8'h0F);
        can_load = !mdl_ov || ordy;
        emode    = (mq.size() == 0) ? im : m_wmode;
        wc       = emode ? (mq.size() == 0) : (mq.size() == 2);
        exp_rdy  = can_load || !(wc || fl);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(mdl_ov));
        if (mdl_ov) begin
            check("out_data", 32'(out_data), 32'(mdl_od));
            check("out_chunks", 32'(out_chunks), mdl_oc);
        end
        last_rdy = in_ready;
        acc = v && exp_rdy;
        if (acc) begin
            if (mq.size() == 0) m_wmode = im;
            mq.push_back(ch);
        end
        n = mq.size();
        w = '0;
        if ((acc && wc) || (fl && can_load && n > 0)) begin
            if (acc && wc && emode) begin
                for (int i = 0; i < 3; i++) w = w | (24'(ch) << (8 * i));
                mdl_oc = 3;
            end else begin
                for (int i = 0; i < n; i++) w = w | (24'(mq[i]) << (8 * (2 - i)));
                mdl_oc = n;
            end
            mdl_ov = 1'b1;
            mdl_od = w;
            mq.delete();
        end else if (ordy) begin
            mdl_ov = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; mode = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chunks", 32'(out_chunks), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_s2_valid", 32'(s_out_valid), 32'd0);
        mq.delete();
        m_wmode = 1'b0;
        mdl_ov  = 1'b0;
        mdl_od  = '0;
        mdl_oc  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // pack
        step(1, 8'hA5, 8'h3C, 0, 0, 1);
        step(1, 8'h12, 8'h34, 0, 0, 1);
        step(1, 8'hF0, 8'h0F, 0, 0, 1);
        #2;
        check("pack_valid", 32'(out_valid), 32'd1);
        check("pack_data", 32'(out_data), 32'hAC14FF);
        check("pack_chunks", 32'(out_chunks), 32'd3);
        step(0, 8'h00, 8'h00, 0, 0, 1);
        #2;
        check("pack_one_cycle", 32'(out_valid), 32'd0);

        // replicate, then the next beat opens a fresh word
        step(1, 8'h9E, 8'h47, 1, 0, 1);
        #2;
        check("repl_data", 32'(out_data), 32'h979797);
        check("repl_chunks", 32'(out_chunks), 32'd3);
        step(1, 8'h12, 8'h34, 0, 0, 1);
        #2;
        check("repl_next_open", 32'(out_valid), 32'd0);
        step(0, 8'h00, 8'h00, 0, 1, 1);
        #2;
        check("flush1_data", 32'(out_data), 32'h140000);
        check("flush1_chunks", 32'(out_chunks), 32'd1);

        // flush with a simultaneous beat, then an empty flush
        step(1, 8'hA5, 8'h3C, 0, 0, 1);
        step(1, 8'h12, 8'h34, 0, 1, 1);
        #2;
        check("flush_data", 32'(out_data), 32'hAC1400);
        check("flush_chunks", 32'(out_chunks), 32'd2);
        step(0, 8'h00, 8'h00, 0, 1, 1);
        #2;
        check("flush_empty", 32'(out_valid), 32'd0);

        // backpressure
        step(1, 8'hA5, 8'h3C, 0, 0, 0);
        step(1, 8'h12, 8'h34, 0, 0, 0);
        step(1, 8'hF0, 8'h0F, 0, 0, 0);
        step(1, 8'hF0, 8'h0F, 0, 0, 0);
        check("bp_beat1_ready", 32'(last_rdy), 32'd1);
        step(1, 8'h12, 8'h34, 0, 0, 0);
        check("bp_beat2_ready", 32'(last_rdy), 32'd1);
        step(1, 8'hA5, 8'h3C, 0, 0, 0);
        check("bp_stall_ready", 32'(last_rdy), 32'd0);
        step(1, 8'hA5, 8'h3C, 0, 0, 0);
        #2;
        check("bp_held_data", 32'(out_data), 32'hAC14FF);
        step(1, 8'hA5, 8'h3C, 0, 0, 1);
        check("bp_release_ready", 32'(last_rdy), 32'd1);
        #2;
        check("bp_reload_valid", 32'(out_valid), 32'd1);
        check("bp_reload_data", 32'(out_data), 32'hFF14AC);
        step(0, 8'h00, 8'h00, 0, 0, 1);

        // reset mid-word
        step(1, 8'hF0, 8'h0F, 0, 0, 1);
        step(1, 8'hF0, 8'h0F, 0, 0, 1);
        do_reset();
        step(1, 8'hA5, 8'h3C, 0, 0, 1);
        step(1, 8'h12, 8'h34, 0, 0, 1);
        step(1, 8'hF0, 8'h0F, 0, 0, 1);
        #2;
        check("rst_word_data", 32'(out_data), 32'hAC14FF);
        check("rst_word_chunks", 32'(out_chunks), 32'd3);

        // mask variant
        do_reset();
        step(1, 8'hA5, 8'h3C, 0, 0, 1);
        step(1, 8'hA5, 8'h3C, 0, 0, 1);
        #2;
        check("mask_not_yet", 32'(m_out_valid), 32'd0);
        step(1, 8'hA5, 8'h3C, 0, 0, 1);
        #2;
        check("mask_valid", 32'(m_out_valid), 32'd1);
        check("mask_data", 32'(m_out_data), 32'h202020);
        check("mask_chunks", 32'(m_out_chunks), 32'd3);

        // SLICE_W=2, BEATS=4 variant
        do_reset();
        step(1, 8'hC0, 8'h00, 0, 0, 1);
        step(1, 8'h40, 8'h01, 0, 0, 1);
        step(1, 8'h80, 8'h02, 0, 0, 1);
        #2;
        check("s2_not_yet", 32'(s_out_valid), 32'd0);
        step(1, 8'h00, 8'h03, 0, 0, 1);
        #2;
        check("s2_valid", 32'(s_out_valid), 32'd1);
        check("s2_data", 32'(s_out_data), 32'hC5A3);
        check("s2_chunks", 32'(s_out_chunks), 32'd4);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 6);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
